// File: rtl/uart_rx_fsm_pkg.sv
// uart_rx_fsm_pkg: shared state encoding, prescale/parity constants and edge-index helpers
package uart_rx_fsm_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [5:0] PRESCALE_8 = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;
  localparam logic EVEN = 1'b0;
  localparam logic ODD = 1'b1;
  // The start-bit detection cycle happens before the counter runs, so bit 0 lags by one edge.
  function automatic logic [5:0] true_edge(input logic [3:0] bit_cnt, input logic [4:0] edge_cnt);
    return (bit_cnt == 4'd0) ? {1'b0, edge_cnt} + 6'd1 : {1'b0, edge_cnt};
  endfunction
  function automatic logic bit_end(input logic [5:0] prescale, input logic [3:0] bit_cnt, input logic [4:0] edge_cnt);
    return true_edge(bit_cnt, edge_cnt) == prescale - 6'd1;
  endfunction
endpackage

// File: rtl/uart_rx_fsm_sampling.sv
// data_sampling: three samples around mid-bit, majority-voted into one bit
module data_sampling
  import uart_rx_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic [5:0] prescale,
  input  logic [4:0] edge_cnt,
  input  logic [3:0] bit_cnt,
  input  logic       enable,
  output logic       sampled_bit
);
  logic [2:0] samples;
  logic [5:0] idx;
  logic [5:0] mid;
  assign idx = true_edge(bit_cnt, edge_cnt);
  assign mid = prescale >> 1;
  assign sampled_bit = (samples[0] & samples[1]) | (samples[0] & samples[2]) | (samples[1] & samples[2]);
  // capture rx_in at the three edges centred on mid-bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) samples <= '0;
    else if (enable) begin
      if (idx == mid - 6'd1) samples[0] <= rx_in;
      if (idx == mid) samples[1] <= rx_in;
      if (idx == mid + 6'd1) samples[2] <= rx_in;
    end
  end
endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART frame receiver FSM with shift register, parity check and error flags
module uart_rx_fsm
  import uart_rx_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_in,
  input  logic       par_en,
  input  logic       par_typ,
  input  logic [5:0] prescale,
  input  logic [3:0] bit_cnt,
  input  logic [4:0] edge_cnt,
  output logic       cnt_enable,
  output logic [7:0] p_data,
  output logic       data_valid,
  output logic       parity_error,
  output logic       stop_error
);
  state_t state;
  logic [7:0] shift;
  logic par_flag;
  logic sampled_bit;
  logic at_end;
  logic frame_ok;
  assign cnt_enable = state != IDLE;
  assign at_end = bit_end(prescale, bit_cnt, edge_cnt);
  assign frame_ok = sampled_bit & ~(par_en & par_flag);
  data_sampling u_sampling (
    .clk(clk),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .prescale(prescale),
    .edge_cnt(edge_cnt),
    .bit_cnt(bit_cnt),
    .enable(cnt_enable),
    .sampled_bit(sampled_bit)
  );
  // frame sequencing, data assembly and registered result/flag outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      shift <= '0;
      par_flag <= 1'b0;
      p_data <= '0;
      data_valid <= 1'b0;
      parity_error <= 1'b0;
      stop_error <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: if (!rx_in) begin
          state <= START;
          par_flag <= 1'b0;
        end
        START: if (at_end) state <= sampled_bit ? IDLE : DATA;
        DATA: if (at_end) begin
          shift <= {sampled_bit, shift[7:1]};
          if (bit_cnt == 4'd8) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (at_end) begin
          par_flag <= sampled_bit != ((par_typ == ODD) ? ~^shift : ^shift);
          state <= STOP;
        end
        STOP: if (at_end) begin
          stop_error <= ~sampled_bit;
          parity_error <= par_en & par_flag;
          data_valid <= frame_ok;
          if (frame_ok) p_data <= shift;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb_uart_rx_fsm: scoreboard bench for uart_rx_fsm with a behavioural edge/bit counter
module tb_uart_rx_fsm;
  import uart_rx_fsm_pkg::*;
  logic clk = 1'b0;
  logic reset_n;
  logic rx_in;
  logic par_en;
  logic par_typ;
  logic [5:0] prescale;
  logic [3:0] bit_cnt;
  logic [4:0] edge_cnt;
  logic cnt_enable;
  logic [7:0] p_data;
  logic data_valid;
  logic parity_error;
  logic stop_error;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic dv_prev = 1'b0;
  logic dv_double = 1'b0;

  uart_rx_fsm dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_in(rx_in),
    .par_en(par_en),
    .par_typ(par_typ),
    .prescale(prescale),
    .bit_cnt(bit_cnt),
    .edge_cnt(edge_cnt),
    .cnt_enable(cnt_enable),
    .p_data(p_data),
    .data_valid(data_valid),
    .parity_error(parity_error),
    .stop_error(stop_error)
  );

  always #5 clk = ~clk;

  // external edge/bit counter: bit 0 is one edge short because detection is uncounted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      edge_cnt <= '0;
    end else if (!cnt_enable) begin
      bit_cnt <= '0;
      edge_cnt <= '0;
    end else if ({1'b0, edge_cnt} == ((bit_cnt == 4'd0) ? prescale - 6'd2 : prescale - 6'd1)) begin
      edge_cnt <= '0;
      bit_cnt <= bit_cnt + 4'd1;
    end else edge_cnt <= edge_cnt + 5'd1;
  end

  always @(negedge clk) begin
    if (data_valid) got_q.push_back(p_data);
    if (data_valid && dv_prev) dv_double = 1'b1;
    dv_prev = data_valid;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int flip_at);
    for (int c = 0; c < int'(prescale); c++) begin
      rx_in = (c == flip_at) ? ~b : b;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input int flip_at);
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(d[i], (i == 2) ? flip_at : -1);
    if (par_en) drive_bit(pbit, -1);
    drive_bit(sbit, -1);
    rx_in = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    rx_in = 1'b1;
    par_en = 1'b0;
    par_typ = EVEN;
    prescale = PRESCALE_8;
    #1;
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL reset cnt_enable got %b expected 0", cnt_enable); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset p_data got %h expected 00", p_data); end
    checks++; if ({data_valid, parity_error, stop_error} !== 3'b000) begin errors++; $display("FAIL reset flags got %b expected 000", {data_valid, parity_error, stop_error}); end
    idle(3);
    reset_n = 1'b1;
    idle(3);
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL reset idle cnt_enable got %b expected 0", cnt_enable); end
  endtask

  task automatic test_nominal;
    logic [7:0] e, g;
    prescale = PRESCALE_8;
    par_en = 1'b0;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b0, 1'b1, -1);
    idle(4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL nominal p_data got %h expected %h", g, e); end
    end
    checks++; if (got_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL nominal pulses extra=%0d missing=%0d expected 0/0", got_q.size(), exp_q.size()); end
    checks++; if ({parity_error, stop_error} !== 2'b00) begin errors++; $display("FAIL nominal flags got %b expected 00", {parity_error, stop_error}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity;
    logic [7:0] e, g;
    prescale = PRESCALE_16;
    par_en = 1'b1;
    par_typ = EVEN;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b0, 1'b1, -1);
    idle(4);
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL parity_good parity_error got %b expected 0", parity_error); end
    send_frame(8'h3C, 1'b1, 1'b1, -1);
    idle(4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL parity p_data got %h expected %h", g, e); end
    end
    checks++; if (got_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL parity pulses extra=%0d missing=%0d expected 0/0", got_q.size(), exp_q.size()); end
    checks++; if (parity_error !== 1'b1) begin errors++; $display("FAIL parity_bad parity_error got %b expected 1", parity_error); end
    checks++; if (stop_error !== 1'b0) begin errors++; $display("FAIL parity_bad stop_error got %b expected 0", stop_error); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL parity_bad p_data got %h expected 3c", p_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_glitch_stop;
    prescale = PRESCALE_16;
    rx_in = 1'b0;
    idle(3);
    rx_in = 1'b1;
    checks++; if (cnt_enable !== 1'b1) begin errors++; $display("FAIL glitch start cnt_enable got %b expected 1", cnt_enable); end
    idle(20);
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL glitch back_idle cnt_enable got %b expected 0", cnt_enable); end
    checks++; if ({parity_error, stop_error} !== 2'b10) begin errors++; $display("FAIL glitch flags got %b expected 10", {parity_error, stop_error}); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL glitch pulses got %0d expected 0", got_q.size()); end
    par_en = 1'b0;
    send_frame(8'h81, 1'b0, 1'b0, -1);
    idle(4);
    checks++; if (stop_error !== 1'b1) begin errors++; $display("FAIL stop_err stop_error got %b expected 1", stop_error); end
    checks++; if (parity_error !== 1'b0) begin errors++; $display("FAIL stop_err parity_error got %b expected 0", parity_error); end
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stop_err pulses got %0d expected 0", got_q.size()); end
    checks++; if (p_data !== 8'h3C) begin errors++; $display("FAIL stop_err p_data got %h expected 3c", p_data); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_back_to_back;
    logic [7:0] e, g;
    prescale = PRESCALE_32;
    par_en = 1'b1;
    par_typ = ODD;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'hAA);
    send_frame(8'h55, ~^8'h55, 1'b1, 15);
    send_frame(8'hAA, ~^8'hAA, 1'b1, 15);
    idle(4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL back_to_back p_data got %h expected %h", g, e); end
    end
    checks++; if (got_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL back_to_back pulses extra=%0d missing=%0d expected 0/0", got_q.size(), exp_q.size()); end
    checks++; if ({parity_error, stop_error} !== 2'b00) begin errors++; $display("FAIL back_to_back flags got %b expected 00", {parity_error, stop_error}); end
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid;
    logic [7:0] e, g;
    prescale = PRESCALE_16;
    par_en = 1'b0;
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    drive_bit(1'b0, -1);
    drive_bit(1'b1, -1);
    rx_in = 1'b0;
    idle(8);
    checks++; if (cnt_enable !== 1'b1 || bit_cnt !== 4'd4) begin errors++; $display("FAIL reset_mid in_frame cnt_enable=%b bit_cnt=%0d expected 1/4", cnt_enable, bit_cnt); end
    reset_n = 1'b0;
    #1;
    checks++; if ({cnt_enable, data_valid, parity_error, stop_error} !== 4'b0000) begin errors++; $display("FAIL reset_mid flags got %b expected 0000", {cnt_enable, data_valid, parity_error, stop_error}); end
    checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL reset_mid p_data got %h expected 00", p_data); end
    idle(3);
    rx_in = 1'b1;
    reset_n = 1'b1;
    idle(5);
    checks++; if (cnt_enable !== 1'b0) begin errors++; $display("FAIL reset_mid idle cnt_enable got %b expected 0", cnt_enable); end
    got_q.delete();
    exp_q.push_back(8'h0F);
    send_frame(8'h0F, 1'b0, 1'b1, -1);
    idle(4);
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL reset_mid p_data got %h expected %h", g, e); end
    end
    checks++; if (got_q.size() != 0 || exp_q.size() != 0) begin errors++; $display("FAIL reset_mid pulses extra=%0d missing=%0d expected 0/0", got_q.size(), exp_q.size()); end
  endtask

  initial begin
    test_reset;
    test_nominal;
    test_parity;
    test_glitch_stop;
    test_back_to_back;
    test_reset_mid;
    checks++; if (dv_double !== 1'b0) begin errors++; $display("FAIL pulse_width data_valid multi-cycle got %b expected 0", dv_double); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
UART_RX_FSM -- requirements
Module: uart_rx_fsm

Interface
- REQ-001 clk  input  1  receiver clock, prescale × baud rate.
- REQ-002 reset_n  input  1  asynchronous, active-low reset.
- REQ-003 rx_in  input  1  serial line, idle high, already synchronised to clk.
- REQ-004 par_en  input  1  1 = frame carries a parity bit.
- REQ-005 par_typ  input  1  0 = even parity, 1 = odd parity.
- REQ-006 prescale  input  6  oversampling ratio; legal values 8, 16, 32 only; other values give undefined behaviour.
- REQ-007 bit_cnt  input  4  bit index from the edge/bit counter.
- REQ-008 edge_cnt  input  5  edge index within the current bit, from the counter.
- REQ-009 cnt_enable  output  1  run/clear control for the edge/bit counter.
- REQ-010 p_data  output  8  last correctly received byte.
- REQ-011 data_valid  output  1  single-cycle pulse: p_data was updated.
- REQ-012 parity_error  output  1  parity mismatch in the last frame.
- REQ-013 stop_error  output  1  stop bit sampled low in the last frame.

Function
- REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP.
- REQ-015 cnt_enable SHALL be combinational and equal to (state != IDLE).
- REQ-016 Frame layout:
  - bit_cnt 0 is the start bit.
  - bit_cnt 1..8 are data bits, LSB first.
  - bit_cnt 9 is parity when par_en = 1.
  - The stop bit follows as bit 9 (no parity) or bit 10 (parity).
- REQ-017 IDLE: rx_in = 0 SHALL move to START on the next edge.
- REQ-018 Start-bit offset: the detection cycle is not counted by the counter. Define the true edge index as edge_cnt+1 when bit_cnt = 0, and edge_cnt otherwise.
- REQ-019 Sampling: let mid = prescale>>1. rx_in SHALL be sampled at true edge indices mid-1, mid and mid+1. The sampled bit SHALL be the majority of those three samples.
- REQ-020 Bit-end condition SHALL be edge_cnt = prescale-2 when bit_cnt = 0, and edge_cnt = prescale-1 otherwise.
- REQ-021 START, at bit end:
  - sampled bit 0 → DATA;
  - sampled bit 1 → IDLE (glitch); no flags change and data_valid is not pulsed.
- REQ-022 DATA, at each bit end: the sampled bit SHALL be shifted right into an 8-bit shift register, entering at the MSB. At the end of bit_cnt = 8, go to PARITY if par_en = 1, else to STOP.
- REQ-023 PARITY, at bit end: the internal parity flag SHALL be set to (sampled bit != expected), where expected = ^shift (even) or ~^shift (odd). The FSM then goes to STOP.
- REQ-024 STOP, at bit end:
  - stop_error SHALL be set to ~sampled bit;
  - parity_error SHALL be set to the internal parity flag, or 0 if par_en = 0;
  - the FSM returns to IDLE.
- REQ-025 data_valid SHALL pulse high for exactly one cycle, and p_data SHALL load the shift register, in the cycle after the STOP decision, only when both error flags are 0.
- REQ-026 On a frame with an error, p_data SHALL hold its previous value.
- REQ-027 Both error flags SHALL hold until the next STOP decision. The internal parity flag SHALL clear on entry to START.
- REQ-028 Back-to-back frames: a start edge in the first cycle after the STOP decision SHALL be detected with no lost cycle.
- REQ-029 par_en, par_typ and prescale SHALL be static during a frame; changes mid-frame give undefined behaviour.

Reset
- REQ-030 Asynchronous assertion SHALL force the following values: state = IDLE, cnt_enable = 0, p_data = 0x00, data_valid = 0, parity_error = 0, stop_error = 0, shift register = 0, samples = 0.
- REQ-031 A reset asserted mid-frame SHALL abandon the frame. After release, the FSM SHALL wait in IDLE for a new falling edge.

Structure
- REQ-032 A shared package SHALL hold:
  - the state encoding;
  - the legal prescale constants (8, 16, 32);
  - the parity-type constants EVEN = 0 and ODD = 1.
- REQ-033 Majority sampling SHALL be a sub-module, data_sampling, with inputs clk, reset_n, rx_in, prescale, edge_cnt, bit_cnt and enable, and output sampled_bit.
- REQ-034 The FSM, shift register, parity check and output registers SHALL live in uart_rx_fsm, instantiated alongside the existing edge/bit counter.

Verification
- REQ-035 Nominal frame: prescale = 8, par_en = 0, send 0xA5 with a high stop bit → exactly one data_valid pulse, p_data = 0xA5, both error flags 0.
- REQ-036 Parity: prescale = 16, par_en = 1, even parity.
  - Send 0x3C with parity bit 0 → data_valid pulses, p_data = 0x3C.
  - Repeat with parity bit 1 → parity_error = 1, no data_valid, p_data stays 0x3C.
- REQ-037 Start glitch and stop error, prescale = 16:
  - rx_in low for 3 cycles, then high → FSM back in IDLE after the start bit, no flag change, no data_valid.
  - Full frame 0x81 with stop bit 0 → stop_error = 1, no data_valid.
- REQ-038 Noise rejection: prescale = 32, odd parity, back-to-back frames 0x55 then 0xAA. Flip rx_in for one cycle at true edge index 15 of data bit 3 → two data_valid pulses, p_data = 0x55 then 0xAA, no errors.
- REQ-039 Reset mid-frame: assert reset_n at bit_cnt = 4 of a frame, then send 0x0F → outputs at reset values during reset, then exactly one data_valid pulse with p_data = 0x0F.
